// File: rtl/cpu_constant.sv
// Shared memory-command and arbiter-state encodings, used by the arbiter, CU and MCU.
package cpu_constant;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTL_W  = 4;
    localparam int unsigned CNT_W  = 4;

    // Bit positions inside the one-hot winner vector
    localparam int unsigned WIN_CPU = 0;
    localparam int unsigned WIN_DMA = 1;

    localparam logic [CTL_W-1:0] MEM_NOP = 4'd0;
    localparam logic [CTL_W-1:0] MEM_RD  = 4'd1;
    localparam logic [CTL_W-1:0] MEM_WR  = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic [CTL_W-1:0] mem_cmd(input logic we);
        return we ? MEM_WR : MEM_RD;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: CPU/DMA request pair plus last-grant pointer -> one-hot winner.
module arb_pick
    import cpu_constant::*;
(
    input  logic       i_cpu_req,
    input  logic       i_dma_req,
    input  logic       i_last_dma,
    output logic [1:0] o_win
);

    // On a tie the requester not granted last wins; a pointer tied to 0 gives DMA priority
    always_comb begin
        o_win = 2'b00;
        if (i_cpu_req && i_dma_req) begin
            o_win[WIN_CPU] = i_last_dma;
            o_win[WIN_DMA] = !i_last_dma;
        end else begin
            o_win[WIN_CPU] = i_cpu_req;
            o_win[WIN_DMA] = i_dma_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA single-port memory arbiter: IDLE -> BUSY (MEM_LAT cycles) -> RESP.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise DMA has fixed priority.
module mem_arbiter
    import cpu_constant::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              cpu_gnt,
    output logic              dma_gnt,
    output logic              cpu_rvalid,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [CTL_W-1:0]  mem_ctl,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner_dma;
    logic              r_cpu_gnt;
    logic              r_dma_gnt;
    logic              r_cpu_rvalid;
    logic              r_dma_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic [CTL_W-1:0]  r_mem_ctl;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        w_win;
    logic              w_last_dma;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_dma;

    // Remember who won the most recent grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_dma <= 1'b0;
        end else if (r_state == ST_IDLE && w_win != 2'b00) begin
            r_last_dma <= w_win[WIN_DMA];
        end
    end

    assign w_last_dma = r_last_dma;
`else
    assign w_last_dma = 1'b0;
`endif

    arb_pick u_arb_pick (
        .i_cpu_req  (cpu_req),
        .i_dma_req  (dma_req),
        .i_last_dma (w_last_dma),
        .o_win      (w_win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner_dma  <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_mem_ctl    <= MEM_NOP;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win != 2'b00) begin
                        r_state     <= ST_BUSY;
                        r_cnt       <= '0;
                        r_owner_dma <= w_win[WIN_DMA];
                        r_cpu_gnt   <= w_win[WIN_CPU];
                        r_dma_gnt   <= w_win[WIN_DMA];
                        r_mem_ctl   <= w_win[WIN_DMA] ? mem_cmd(dma_we) : mem_cmd(cpu_we);
                        r_mem_addr  <= w_win[WIN_DMA] ? dma_addr : cpu_addr;
                        r_mem_wdata <= w_win[WIN_DMA] ? dma_wdata : cpu_wdata;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_W'(MEM_LAT - 1)) begin
                        r_state      <= ST_RESP;
                        r_mem_ctl    <= MEM_NOP;
                        r_cpu_rvalid <= !r_owner_dma;
                        r_dma_rvalid <= r_owner_dma;
                        if (r_mem_ctl == MEM_RD) begin
                            if (r_owner_dma) r_dma_rdata <= mem_rdata;
                            else             r_cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_ctl <= MEM_NOP;
                end
            endcase
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign dma_gnt    = r_dma_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign mem_ctl    = r_mem_ctl;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance share all inputs.
module tb_mem_arbiter;
    import cpu_constant::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

    logic        d1_cpu_gnt, d1_dma_gnt, d1_cpu_rvalid, d1_dma_rvalid;
    logic [31:0] d1_cpu_rdata, d1_dma_rdata, d1_mem_addr, d1_mem_wdata;
    logic [3:0]  d1_mem_ctl;
    logic        d3_cpu_gnt, d3_dma_gnt, d3_cpu_rvalid, d3_dma_rvalid;
    logic [31:0] d3_cpu_rdata, d3_dma_rdata, d3_mem_addr, d3_mem_wdata;
    logic [3:0]  d3_mem_ctl;
    logic [135:0] d1_vec, d3_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_gnt(d1_cpu_gnt), .dma_gnt(d1_dma_gnt),
        .cpu_rvalid(d1_cpu_rvalid), .dma_rvalid(d1_dma_rvalid),
        .cpu_rdata(d1_cpu_rdata), .dma_rdata(d1_dma_rdata),
        .mem_ctl(d1_mem_ctl), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_gnt(d3_cpu_gnt), .dma_gnt(d3_dma_gnt),
        .cpu_rvalid(d3_cpu_rvalid), .dma_rvalid(d3_dma_rvalid),
        .cpu_rdata(d3_cpu_rdata), .dma_rdata(d3_dma_rdata),
        .mem_ctl(d3_mem_ctl), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [135:0] pk(input logic cg, input logic dg, input logic cv,
                                        input logic dv, input logic [3:0] ctl,
                                        input logic [31:0] a, input logic [31:0] w,
                                        input logic [31:0] cr, input logic [31:0] dr);
        return {cg, dg, cv, dv, ctl, a, w, cr, dr};
    endfunction

    assign d1_vec = pk(d1_cpu_gnt, d1_dma_gnt, d1_cpu_rvalid, d1_dma_rvalid, d1_mem_ctl,
                       d1_mem_addr, d1_mem_wdata, d1_cpu_rdata, d1_dma_rdata);
    assign d3_vec = pk(d3_cpu_gnt, d3_dma_gnt, d3_cpu_rvalid, d3_dma_rvalid, d3_mem_ctl,
                       d3_mem_addr, d3_mem_wdata, d3_cpu_rdata, d3_dma_rdata);

    typedef struct {
        logic         creq, cwe;
        logic [31:0]  caddr, cwd;
        logic         dreq, dwe;
        logic [31:0]  daddr, dwd, rdata;
        logic [135:0] exp;
    } vec_t;

    function automatic vec_t mkv(input logic creq, input logic cwe, input logic [31:0] caddr,
                                 input logic [31:0] cwd, input logic dreq, input logic dwe,
                                 input logic [31:0] daddr, input logic [31:0] dwd,
                                 input logic [31:0] rdata, input logic [135:0] exp);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.rdata = rdata; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0;
    endtask

    // Called just after a rising edge; releases reset away from any edge
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #10;
        rst = 1'b1;
    endtask

    vec_t tbl[15];

    initial begin
        int bad;
        logic exp_dma;

        // MEM_LAT=1 cycle table: inputs driven before the edge, outputs checked after it
        tbl[0]  = mkv(1, 0, 32'd26, 0, 0, 0, 0, 0, 32'h1234,
                      pk(1, 0, 0, 0, MEM_RD,  32'd26, 0, 0, 0));
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234,
                      pk(0, 0, 1, 0, MEM_NOP, 32'd26, 0, 32'h1234, 0));
        tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,
                      pk(0, 0, 0, 0, MEM_NOP, 32'd26, 0, 32'h1234, 0));
        tbl[3]  = mkv(0, 0, 0, 0, 1, 1, 32'd15, 32'd7, 0,
                      pk(0, 1, 0, 0, MEM_WR,  32'd15, 32'd7, 32'h1234, 0));
        tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE,
                      pk(0, 0, 0, 1, MEM_NOP, 32'd15, 32'd7, 32'h1234, 0));
        tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,
                      pk(0, 0, 0, 0, MEM_NOP, 32'd15, 32'd7, 32'h1234, 0));
        tbl[6]  = mkv(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 32'hFFFFFFFF,
                      pk(1, 0, 0, 0, MEM_WR,  32'h40, 32'hDEADBEEF, 32'h1234, 0));
        tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF,
                      pk(0, 0, 1, 0, MEM_NOP, 32'h40, 32'hDEADBEEF, 32'h1234, 0));
        tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,
                      pk(0, 0, 0, 0, MEM_NOP, 32'h40, 32'hDEADBEEF, 32'h1234, 0));
        tbl[9]  = mkv(0, 0, 0, 0, 1, 0, 32'h200, 32'd5, 0,
                      pk(0, 1, 0, 0, MEM_RD,  32'h200, 32'd5, 32'h1234, 0));
        tbl[10] = mkv(1, 0, 32'h80, 0, 0, 0, 0, 0, 32'hA5A50001,
                      pk(0, 0, 0, 1, MEM_NOP, 32'h200, 32'd5, 32'h1234, 32'hA5A50001));
        tbl[11] = mkv(1, 0, 32'h80, 0, 0, 0, 0, 0, 0,
                      pk(0, 0, 0, 0, MEM_NOP, 32'h200, 32'd5, 32'h1234, 32'hA5A50001));
        tbl[12] = mkv(1, 0, 32'h80, 0, 0, 0, 0, 0, 0,
                      pk(1, 0, 0, 0, MEM_RD,  32'h80, 0, 32'h1234, 32'hA5A50001));
        tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D,
                      pk(0, 0, 1, 0, MEM_NOP, 32'h80, 0, 32'h0BADF00D, 32'hA5A50001));
        tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,
                      pk(0, 0, 0, 0, MEM_NOP, 32'h80, 0, 32'h0BADF00D, 32'hA5A50001));

        idle_inputs();
        rst = 1'b0;
        #12;
        check("reset_d1", d1_vec, '0);
        check("reset_d3", d3_vec, '0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe;
            cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            dma_req = tbl[i].dreq; dma_we = tbl[i].dwe;
            dma_addr = tbl[i].daddr; dma_wdata = tbl[i].dwd;
            mem_rdata = tbl[i].rdata;
            step();
            check($sformatf("row%0d", i), d1_vec, tbl[i].exp);
        end

        // Both requesters held for four transactions
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h100;
        dma_req = 1'b1; dma_addr = 32'h200;
        for (int t = 0; t < 4; t++) begin
            step();
            exp_dma = RR ? (t % 2 == 0) : 1'b1;
            check($sformatf("both_req_t%0d", t), 136'({d1_cpu_gnt, d1_dma_gnt, d1_mem_addr}),
                  136'({!exp_dma, exp_dma, exp_dma ? 32'h200 : 32'h100}));
            step();
            step();
        end

        // MEM_LAT=3 DMA write: WR for three cycles, rvalid on the fourth
        do_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'd15; dma_wdata = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("lat3_wr_c%0d", c), d3_vec,
                  pk(0, c == 1, 0, c == 4, (c <= 3) ? MEM_WR : MEM_NOP, 32'd15, 32'd7, 0, 0));
            if (c == 1) dma_req = 1'b0;
        end

        // Reset asserted in the second BUSY cycle aborts the transaction
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h44; mem_rdata = 32'h3333;
        step();
        check("abort_c1", d3_vec, pk(1, 0, 0, 0, MEM_RD, 32'h44, 0, 0, 0));
        cpu_req = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        check("abort_now_d3", d3_vec, '0);
        check("abort_now_d1", d1_vec, '0);
        #10;
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (d3_cpu_rvalid || d3_dma_rvalid || d3_mem_ctl != MEM_NOP || d3_cpu_gnt) bad++;
        end
        check("abort_quiet", 136'(bad), 136'(0));

        // Request changes during BUSY do not disturb the active CPU read
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h30; mem_rdata = 32'h7777;
        step();
        check("chg_c1", d3_vec, pk(1, 0, 0, 0, MEM_RD, 32'h30, 0, 0, 0));
        cpu_req = 1'b0; cpu_addr = 32'h99;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h55; dma_wdata = 32'h66;
        step();
        check("chg_c2", d3_vec, pk(0, 0, 0, 0, MEM_RD,  32'h30, 0, 0, 0));
        step();
        check("chg_c3", d3_vec, pk(0, 0, 0, 0, MEM_RD,  32'h30, 0, 0, 0));
        step();
        check("chg_c4", d3_vec, pk(0, 0, 1, 0, MEM_NOP, 32'h30, 0, 32'h7777, 0));
        step();
        check("chg_c5", d3_vec, pk(0, 0, 0, 0, MEM_NOP, 32'h30, 0, 32'h7777, 0));
        step();
        check("chg_c6", d3_vec, pk(0, 1, 0, 0, MEM_WR, 32'h55, 32'h66, 32'h7777, 0));
        dma_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
